// File: rtl/axi_line_refill.sv
// Cache-miss refill controller: commands one line-sized INCR burst on axi_master,
// snoops the R channel into a line buffer and hands the line back to the cache.
module axi_line_refill #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WORDS     = 4,
  parameter int READ_BURST_LEN = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_valid,
  output logic                             miss_ready,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  output logic                             start_read,
  output logic [ADDR_WIDTH-1:0]            target_read_addr,
  output logic [READ_BURST_LEN-1:0]        target_read_burst_len,
  input  logic                             done_read,
  input  logic                             RVALID,
  input  logic                             RREADY,
  input  logic [DATA_WIDTH-1:0]            RDATA,
  input  logic                             RLAST,
  input  logic [1:0]                       RRESP,
  output logic                             fill_valid,
  input  logic                             fill_ready,
  output logic [ADDR_WIDTH-1:0]            fill_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_data,
  output logic                             fill_err
);

  localparam int OFF   = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, PRESENT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             beat;
  logic             over;
  logic             err_next;
  logic [CNT_W-1:0] cnt_next;

  assign miss_ready = (state == IDLE);

  // Counter is one bit wider than the word index so excess beats are visible
  // and can be flagged instead of wrapping onto word 0.
  always_comb begin
    beat     = RVALID && RREADY;
    over     = (cnt >= FULL);
    err_next = err;
    cnt_next = cnt;
    if (beat) begin
      if (over || (RRESP != 2'b00) || (RLAST && (cnt != LAST))) err_next = 1'b1;
      if (!over) cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      err                   <= 1'b0;
      start_read            <= 1'b0;
      target_read_addr      <= '0;
      target_read_burst_len <= '0;
      fill_valid            <= 1'b0;
      fill_addr             <= '0;
      fill_data             <= '0;
      fill_err              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid) begin
            target_read_addr      <= miss_addr & ~OFF_MASK;
            target_read_burst_len <= READ_BURST_LEN'(LINE_WORDS - 1);
            start_read            <= 1'b1;
            cnt                   <= '0;
            err                   <= 1'b0;
            fill_data             <= '0;
            state                 <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt_next;
          err <= err_next;
          if (beat && !over) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
              if (cnt == CNT_W'(k)) fill_data[k*DATA_WIDTH +: DATA_WIDTH] <= RDATA;
            end
          end
          // A beat on the done_read edge is folded into both data and error status.
          if (done_read) begin
            state                 <= PRESENT;
            start_read            <= 1'b0;
            target_read_addr      <= '0;
            target_read_burst_len <= '0;
            fill_valid            <= 1'b1;
            fill_addr             <= target_read_addr;
            fill_err              <= err_next || (cnt_next != FULL);
          end
        end
        PRESENT: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_refill.sv
// Scoreboard bench for axi_line_refill: the bench plays cache, axi_master and slave,
// pushing the expected line per miss and popping it at the fill handshake.
module tb_axi_line_refill;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int BL = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_valid;
  logic              miss_ready;
  logic [AW-1:0]     miss_addr;
  logic              start_read;
  logic [AW-1:0]     target_read_addr;
  logic [BL-1:0]     target_read_burst_len;
  logic              done_read;
  logic              RVALID;
  logic              RREADY;
  logic [DW-1:0]     RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic              fill_valid;
  logic              fill_ready;
  logic [AW-1:0]     fill_addr;
  logic [LW*DW-1:0]  fill_data;
  logic              fill_err;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LW*DW-1:0] data;
    logic             err;
  } line_t;

  line_t sb[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  axi_line_refill #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .READ_BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .start_read(start_read), .target_read_addr(target_read_addr),
    .target_read_burst_len(target_read_burst_len), .done_read(done_read),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleR();
    RVALID = 1'b0; RREADY = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  // One full miss/burst/fill transaction. Beats are driven one per cycle;
  // resp_beat/last_beat pick which beat carries an error response or RLAST.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] dbase,
                               input int nbeats, input int resp_beat, input int last_beat,
                               input int fill_delay, input bit done_with_last,
                               input bit hold_next, input logic [AW-1:0] next_addr);
    line_t exp;
    line_t got;
    exp.addr = addr & ~AW'(LW*DW/8 - 1);
    exp.data = '0;
    exp.err  = (nbeats != LW);
    for (int k = 0; k < nbeats; k++) begin
      if (k < LW) exp.data[k*DW +: DW] = dbase + DW'(k);
      if (k == resp_beat) exp.err = 1'b1;
      if (k == last_beat && k != LW - 1) exp.err = 1'b1;
    end
    sb.push_back(exp);

    @(negedge clk);
    checkOutput("miss_ready_idle", miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(negedge clk);
    miss_valid = 1'b0;
    checkOutput("start_read_rise", start_read, 1);
    checkOutput("target_addr", target_read_addr, exp.addr);
    checkOutput("target_len", target_read_burst_len, LW - 1);
    checkOutput("miss_ready_req", miss_ready, 0);

    for (int k = 0; k < nbeats; k++) begin
      RVALID    = 1'b1;
      RREADY    = 1'b1;
      RDATA     = dbase + DW'(k);
      RRESP     = (k == resp_beat) ? 2'b10 : 2'b00;
      RLAST     = (k == last_beat);
      done_read = done_with_last && (k == nbeats - 1);
      @(negedge clk);
      if (!done_read) checkOutput("start_read_held", start_read, 1);
    end
    idleR();
    if (!done_with_last) begin
      done_read = 1'b1;
      @(negedge clk);
    end
    done_read = 1'b0;
    checkOutput("start_read_drop", start_read, 0);
    checkOutput("target_addr_clr", target_read_addr, 0);
    checkOutput("target_len_clr", target_read_burst_len, 0);

    for (int i = 0; i < 10 && !fill_valid; i++) @(negedge clk);
    checkOutput("fill_valid_rise", fill_valid, 1);

    if (hold_next) begin
      miss_valid = 1'b1;
      miss_addr  = next_addr;
    end
    for (int i = 0; i < fill_delay; i++) begin
      RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'hDEAD_BEEF; RLAST = 1'b1;
      @(negedge clk);
      checkOutput("fill_valid_hold", fill_valid, 1);
      checkOutput("fill_data_hold", fill_data, exp.data);
      checkOutput("miss_ready_present", miss_ready, 0);
    end
    idleR();

    fill_ready = 1'b1;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 1, 0);
    end else begin
      got = sb.pop_front();
      checkOutput("fill_addr", fill_addr, got.addr);
      checkOutput("fill_data", fill_data, got.data);
      checkOutput("fill_err", fill_err, got.err);
    end
    @(negedge clk);
    fill_ready = 1'b0;
    miss_valid = 1'b0;
    checkOutput("fill_valid_fall", fill_valid, 0);
    checkOutput("fill_data_kept", fill_data, exp.data);
    checkOutput("miss_ready_back", miss_ready, 1);
    checkOutput("no_accept_on_fill", start_read, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; done_read = 1'b0; fill_ready = 1'b0;
    idleR();
    #1;
    checkOutput("rst_miss_ready", miss_ready, 1);
    checkOutput("rst_start_read", start_read, 0);
    checkOutput("rst_fill_valid", fill_valid, 0);
    checkOutput("rst_fill_data", fill_data, 0);
    checkOutput("rst_fill_err", fill_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h7C, 32'hA0, 4, -1, 3, 5, 1'b0, 1'b1, 32'h7C);
    applyStimulus(32'h1008, 32'hB0, 4, 2, 3, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h2044, 32'hC0, 2, -1, 1, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h3000, 32'hF0, 5, -1, 4, 1, 1'b0, 1'b0, 32'h0);

    // Reset asserted mid-burst, on the beat-2 handshake.
    @(negedge clk);
    miss_valid = 1'b1; miss_addr = 32'h300;
    @(negedge clk);
    miss_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h55 + DW'(k);
      @(negedge clk);
    end
    RDATA = 32'h57;
    rst   = 1'b1;
    #1;
    checkOutput("midrst_start_read", start_read, 0);
    checkOutput("midrst_target_addr", target_read_addr, 0);
    checkOutput("midrst_target_len", target_read_burst_len, 0);
    checkOutput("midrst_fill_valid", fill_valid, 0);
    checkOutput("midrst_fill_addr", fill_addr, 0);
    checkOutput("midrst_fill_data", fill_data, 0);
    checkOutput("midrst_fill_err", fill_err, 0);
    checkOutput("midrst_miss_ready", miss_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idleR();
    applyStimulus(32'h200, 32'h11, 4, -1, 3, 2, 1'b0, 1'b0, 32'h0);

    applyStimulus(32'h123, 32'hD0, 4, -1, 3, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h5, 32'hE0, 4, -1, 3, 0, 1'b1, 1'b0, 32'h0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
